// File: rtl/i2c_byte_master.sv
// ---------------------------------------------------------------------------
// i2c_byte_master
//   Byte-level I2C master engine. Executes one START, WRITE, READ or STOP
//   command at a time. It generates SCL push-pull and an open-drain enable for
//   SDA. Each SCL period is split into four quarters of QTR+1 core cycles.
//   There is no clock stretching, no arbitration and no protocol-order checking.
//
// Parameters
//   QTR          cycles per SCL quarter-period minus 1 (>= 3)
// Ports
//   clk          core clock
//   rst          asynchronous active-high reset
//   i_cmd_valid  command request, accepted when o_cmd_ready is high
//   o_cmd_ready  idle and accepting a command
//   i_cmd        0=START 1=WRITE 2=READ 3=STOP
//   i_wdata      byte to send on WRITE
//   i_rd_nack    9th bit of a READ (1=NACK, 0=ACK)
//   o_done       one-cycle completion pulse
//   o_rdata      last byte received by READ
//   o_ack_err    slave NACKed the last WRITE
//   o_busy       command in progress
//   o_scl        SCL (push-pull)
//   o_sda_oe     1 pulls SDA low, 0 releases it
//   i_sda        SDA pad value (asynchronous)
// ---------------------------------------------------------------------------
module i2c_byte_master #(
    parameter int QTR = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd,
    input  logic [7:0] i_wdata,
    input  logic       i_rd_nack,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_ack_err,
    output logic       o_busy,
    output logic       o_scl,
    output logic       o_sda_oe,
    input  logic       i_sda
);

    localparam int              QW    = $clog2(QTR + 1);
    localparam logic [QW-1:0]   QTR_L = QW'(QTR);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

    state_t          r_state;
    logic [QW-1:0]   r_qcnt;
    logic [1:0]      r_quarter;
    logic [3:0]      r_bit;
    logic [1:0]      r_cmd;
    logic            r_rd_nack;
    logic [7:0]      r_shift;
    logic            r_sda_meta;
    logic            r_sda_sync;
    logic            r_scl;
    logic            r_sda_oe;
    logic            r_done;
    logic [7:0]      r_rdata;
    logic            r_ack_err;
    logic            r_busy;
    logic            r_ready;

    logic            w_qend;
    logic [1:0]      w_nq;
    logic            w_is_read;

    assign w_qend    = (r_qcnt == '0);
    assign w_nq      = r_quarter + 2'd1;
    assign w_is_read = (r_cmd == CMD_READ);

    // SDA drive for a bit cell: data cells of a WRITE pull low for a 0 bit,
    // READ data cells release; the 9th cell is the ACK slot, driven only by a
    // READ that acknowledges.
    function automatic logic cell_oe(input logic is_read, input logic last,
                                     input logic bit7, input logic nack);
        if (last) return is_read & ~nack;
        return ~is_read & ~bit7;
    endfunction

    // Two-flop synchronizer for the asynchronous SDA pad; idles high like the bus.
    // NOTE: asynchronous reset is used for every state flop here; there are no
    // memories, so nothing is left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_quarter <= 2'd0;
            r_bit     <= 4'd0;
            r_cmd     <= CMD_START;
            r_rd_nack <= 1'b0;
            r_shift   <= 8'h00;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= 8'h00;
            r_ack_err <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_cmd     <= i_cmd;
                        r_rd_nack <= i_rd_nack;
                        r_shift   <= i_wdata;
                        r_qcnt    <= QTR_L;
                        r_quarter <= 2'd0;
                        r_bit     <= 4'd0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                        r_scl     <= 1'b0;   // Q0 of every command has SCL low
                        case (i_cmd)
                            CMD_START: begin
                                r_state  <= S_START;
                                r_sda_oe <= 1'b0;
                            end
                            CMD_STOP: begin
                                r_state  <= S_STOP;
                                r_sda_oe <= 1'b1;
                            end
                            default: begin
                                r_state  <= S_BIT;
                                r_sda_oe <= cell_oe(i_cmd == CMD_READ, 1'b0,
                                                    i_wdata[7], i_rd_nack);
                            end
                        endcase
                    end
                end

                S_START, S_STOP, S_BIT: begin
                    if (!w_qend) begin
                        r_qcnt <= r_qcnt - 1'b1;
                    end else begin
                        r_qcnt    <= QTR_L;
                        r_quarter <= w_nq;
                        if (r_quarter == 2'd3) begin
                            if (r_state != S_BIT || r_bit == 4'd8) begin
                                // Last quarter of the command: lines keep their
                                // final values until the next command.
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                if (r_state == S_BIT) begin
                                    if (w_is_read) r_rdata   <= r_shift;
                                    else           r_ack_err <= r_sda_sync;
                                end
                            end else begin
                                r_bit    <= r_bit + 4'd1;
                                r_shift  <= {r_shift[6:0], r_sda_sync};
                                r_scl    <= 1'b0;
                                // r_shift[6] becomes the MSB after this shift.
                                r_sda_oe <= cell_oe(w_is_read, r_bit == 4'd7,
                                                    r_shift[6], r_rd_nack);
                            end
                        end else begin
                            case (r_state)
                                S_START: begin
                                    r_scl    <= (w_nq != 2'd3);
                                    r_sda_oe <= (w_nq != 2'd1);
                                end
                                S_STOP: begin
                                    r_scl    <= 1'b1;
                                    r_sda_oe <= (w_nq == 2'd1);
                                end
                                default: begin
                                    r_scl <= w_nq[1];  // high in Q2-Q3
                                end
                            endcase
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_ack_err   = r_ack_err;
    assign o_scl       = r_scl;
    assign o_sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_byte_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_master
//   Scoreboard bench for i2c_byte_master with QTR=3 (quarter = 4 cycles,
//   START/STOP = 16 cycles, byte = 144 cycles). Stimulus pushes the expected
//   completion (cycle, o_rdata, o_ack_err) at acceptance; a monitor pops and
//   compares on every o_done. Directed checks cover reset, line sequencing,
//   the SDA bit trace, the ACK slot, busy hold-off and mid-command reset.
// ---------------------------------------------------------------------------
module tb_i2c_byte_master;

    localparam int QTR = 3;
    localparam int QC  = QTR + 1;

    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_STOP  = 2'd3;

    // {scl,oe} per quarter, Q0 in the top bits
    localparam logic [7:0] PAT_START = 8'b00_10_11_01;
    localparam logic [7:0] PAT_STOP  = 8'b01_11_10_10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [1:0] i_cmd = 2'd0;
    logic [7:0] i_wdata = 8'h00;
    logic       i_rd_nack = 1'b0;
    logic       o_done;
    logic [7:0] o_rdata;
    logic       o_ack_err;
    logic       o_busy;
    logic       o_scl;
    logic       o_sda_oe;
    logic       i_sda;
    logic       slave_low = 1'b0;

    assign i_sda = ~(o_sda_oe | slave_low);

    i2c_byte_master #(.QTR(QTR)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd       (i_cmd),
        .i_wdata     (i_wdata),
        .i_rd_nack   (i_rd_nack),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_ack_err   (o_ack_err),
        .o_busy      (o_busy),
        .o_scl       (o_scl),
        .o_sda_oe    (o_sda_oe),
        .i_sda       (i_sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         done_cyc;
        logic [7:0] rdata;
        logic       ack_err;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic       trace_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_ack = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus SDA seen at each SCL rising edge
    always @(posedge o_scl) trace_q.push_back(i_sda);

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && o_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("rdata", int'(o_rdata), int'(mon_e.rdata));
                check("ack_err", int'(o_ack_err), int'(mon_e.ack_err));
            end
        end
    end

    // Issue a command at a negedge; returns one negedge after acceptance
    // (first execution cycle). slv_byte / slv_ack describe the slave's reply.
    task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] wd,
                            input logic nack, input logic [7:0] slv_byte,
                            input logic slv_ack, input bit hold, output int acc);
        int dur;
        i_cmd       = cmd;
        i_wdata     = wd;
        i_rd_nack   = nack;
        i_cmd_valid = 1'b1;
        acc         = -1;
        for (int t = 0; t < 400; t++) begin
            if (o_cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            check("accept_timeout", 0, 1);
            i_cmd_valid = 1'b0;
            return;
        end
        if (cmd == C_READ)  m_rdata = slv_byte;
        if (cmd == C_WRITE) m_ack   = ~slv_ack;
        dur = (cmd == C_READ || cmd == C_WRITE) ? 36 * QC : 4 * QC;
        sb_q.push_back('{acc + 1 + dur, m_rdata, m_ack});
        @(negedge clk);
        if (!hold) i_cmd_valid = 1'b0;
    endtask

    // Play the slave for 9 bit cells (mask bit 8 = cell 1); checks the
    // master's SDA enable across the whole 9th cell.
    task automatic drive_slave(input logic [8:0] low_mask, input logic exp_oe9);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 9; k++) begin
            slave_low = low_mask[8-k];
            for (int j = 0; j < 4 * QC; j++) begin
                if (k == 8 && o_sda_oe !== exp_oe9) ok = 1'b0;
                @(negedge clk);
            end
        end
        slave_low = 1'b0;
        check("cell9_sda_oe_stable", int'(ok), 1);
    endtask

    // Check {scl,oe} mid-quarter for the 4 quarters of START/STOP
    task automatic check_quarters(input string name, input logic [7:0] pat);
        for (int q = 0; q < 4; q++) begin
            @(negedge clk);
            check($sformatf("%s_q%0d", name, q), int'({o_scl, o_sda_oe}),
                  int'(pat[7-2*q -: 2]));
            repeat (QC - 1) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int stop_acc;
        logic [8:0] tr;
        int tr_n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_scl", int'(o_scl), 1);
        check("rst_sda_oe", int'(o_sda_oe), 0);
        check("rst_cmd_ready", int'(o_cmd_ready), 1);
        check("rst_rdata", int'(o_rdata), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ack_err", int'(o_ack_err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // START from idle bus
        send_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("start_busy", int'(o_busy), 1);
        check_quarters("start", PAT_START);
        @(negedge clk);
        trace_q.delete();

        // WRITE 0xA5, slave ACKs
        send_cmd(C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, acc);
        drive_slave(9'b0_0000_0001, 1'b0);
        tr_n = trace_q.size();
        tr = '0;
        while (trace_q.size() > 0) tr = {tr[7:0], trace_q.pop_front()};
        check("a5_trace_len", tr_n, 9);
        check("a5_sda_trace", int'(tr), 9'h14A);
        @(negedge clk);
        check("byte_hold_scl", int'(o_scl), 1);
        check("byte_hold_sda_oe", int'(o_sda_oe), 0);

        // WRITE 0x3C, no slave -> NACK
        send_cmd(C_WRITE, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        drive_slave(9'b0, 1'b0);

        // READ 0x96 with NACK, then 0x69 with ACK
        send_cmd(C_READ, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0, acc);
        drive_slave({~8'h96, 1'b0}, 1'b0);
        send_cmd(C_READ, 8'h00, 1'b0, 8'h69, 1'b0, 1'b0, acc);
        drive_slave({~8'h69, 1'b0}, 1'b1);
        @(negedge clk);
        check("read_ack_hold_scl", int'(o_scl), 1);
        check("read_ack_hold_sda_oe", int'(o_sda_oe), 1);

        // STOP with i_cmd_valid held; next START must wait for o_done
        send_cmd(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, stop_acc);
        check_quarters("stop", PAT_STOP);
        send_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("accept_after_done", acc, stop_acc + 2 + 4 * QC);
        check_quarters("rstart", PAT_START);
        send_cmd(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        repeat (4 * QC + 2) @(negedge clk);
        check("stop_final_scl", int'(o_scl), 1);
        check("stop_final_sda_oe", int'(o_sda_oe), 0);

        // Reset during bit 4 of a WRITE 0x00 (SCL high, SDA driven low)
        send_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        repeat (4 * QC) @(negedge clk);
        send_cmd(C_WRITE, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        repeat (3 * 4 * QC + 2 * QC) @(negedge clk);
        check("bit4_scl_before_rst", int'(o_scl), 1);
        check("bit4_sda_oe_before_rst", int'(o_sda_oe), 1);
        rst = 1'b1;
        #1;
        check("midrst_scl", int'(o_scl), 1);
        check("midrst_sda_oe", int'(o_sda_oe), 0);
        check("midrst_done", int'(o_done), 0);
        sb_q.delete();
        m_rdata = 8'h00;
        m_ack   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(o_cmd_ready), 1);
        check("post_rst_busy", int'(o_busy), 0);
        repeat (200) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
